// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the memory macro and mem_arbiter.
// Arbiter side uses the slave modport; datapath and memory model use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // Handshake: a port raises its request (if_req, or dm_rd/dm_wr) and holds it,
  // with address/data stable, until its one-cycle done pulse; stall is
  // request & ~done. Toward memory, mem_en is a single-cycle issue strobe that
  // qualifies mem_wr/mem_addr/mem_wdata, and mem_rdata is valid exactly LATENCY
  // cycles after that strobe with no back-pressure.

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  // data port
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;

  // memory macro
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // status
  logic              busy;
  logic              err;

  modport slave (
    input  if_req, if_addr,
    input  dm_rd, dm_wr, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_done, if_stall,
    output dm_rdata, dm_done, dm_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output busy, err
  );

  modport master (
    output if_req, if_addr,
    output dm_rd, dm_wr, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_done, if_stall,
    input  dm_rdata, dm_done, dm_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  busy, err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer sharing one fixed-latency memory between fetch and data ports.
// Optional feature macro: ARB_RR_EN selects round-robin tie-break instead of fixed DM-over-IF.
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  state_t            state;
  state_t            state_nx;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nx;
  logic              own_dm;
  logic              own_dm_nx;
  logic              own_wr;
  logic              own_wr_nx;
  logic              err_q;
  logic              err_nx;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] if_rdata_nx;
  logic [DATA_W-1:0] dm_rdata_q;
  logic [DATA_W-1:0] dm_rdata_nx;

  logic              req_if;
  logic              req_dm;
  logic              prio_dm;
  logic              dm_win;
  logic              grant;
  logic              issue_en;
  logic              issue_wr;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  assign req_if = bus.if_req;
  assign req_dm = bus.dm_rd | bus.dm_wr;
  assign dm_win = req_dm & (prio_dm | ~req_if);

`ifdef ARB_RR_EN
  // Remembers who won the most recent grant; resets to IF so DM takes the first tie.
  logic last_dm;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dm <= 1'b0;
    end else if (grant) begin
      last_dm <= dm_win;
    end
  end

  assign prio_dm = ~last_dm;
`else
  assign prio_dm = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      own_dm     <= 1'b0;
      own_wr     <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      own_dm     <= own_dm_nx;
      own_wr     <= own_wr_nx;
      err_q      <= err_nx;
      if_rdata_q <= if_rdata_nx;
      dm_rdata_q <= dm_rdata_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    own_dm_nx   = own_dm;
    own_wr_nx   = own_wr;
    err_nx      = err_q;
    if_rdata_nx = if_rdata_q;
    dm_rdata_nx = dm_rdata_q;
    grant       = 1'b0;
    issue_en    = 1'b0;
    issue_wr    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;

    case (state)
      IDLE: begin
        // Mealy grant: the winner's address goes to memory in the request cycle.
        if (req_if || req_dm) begin
          grant    = 1'b1;
          issue_en = 1'b1;
          if (dm_win) begin
            issue_wr    = bus.dm_wr;
            issue_addr  = bus.dm_addr;
            issue_wdata = bus.dm_wdata;
          end else begin
            issue_addr  = bus.if_addr;
          end
          own_dm_nx = dm_win;
          own_wr_nx = dm_win & bus.dm_wr;
          if (dm_win && bus.dm_rd && bus.dm_wr) begin
            err_nx = 1'b1;
          end
          cnt_nx   = CNT_LOAD;
          state_nx = WAIT;
        end
      end

      WAIT: begin
        if (cnt != 3'd0) begin
          cnt_nx = cnt - 3'd1;
        end else begin
          // mem_rdata is valid this cycle; writes leave both read registers alone.
          if (!own_wr) begin
            if (own_dm) begin
              dm_rdata_nx = bus.mem_rdata;
            end else begin
              if_rdata_nx = bus.mem_rdata;
            end
          end
          state_nx = DONE;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = issue_en;
  assign bus.mem_wr    = issue_wr;
  assign bus.mem_addr  = issue_addr;
  assign bus.mem_wdata = issue_wdata;

  assign bus.if_done  = (state == DONE) & ~own_dm;
  assign bus.dm_done  = (state == DONE) &  own_dm;
  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.dm_stall = (bus.dm_rd | bus.dm_wr) & ~bus.dm_done;

  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.busy     = (state != IDLE);
  assign bus.err      = err_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner sequences
// and randomized traffic against a transaction-timeline reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b0 ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
  logic [1:0] st0;
  logic [1:0] st1;

  mem_arbiter #(.LATENCY(2), .ADDR_W(16), .DATA_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .dbg_state(st0));
  mem_arbiter #(.LATENCY(1), .ADDR_W(16), .DATA_W(16)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .dbg_state(st1));

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        if_req;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrdata;
    logic        exp_wr;
    logic        exp_dm;
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_dm_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    b0.if_req = 0; b0.if_addr = '0; b0.dm_rd = 0; b0.dm_wr = 0;
    b0.dm_addr = '0; b0.dm_wdata = '0; b0.mem_rdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.dm_rd = 0; b1.dm_wr = 0;
    b1.dm_addr = '0; b1.dm_wdata = '0; b1.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // One isolated access on the LATENCY=2 instance, checked cycle by cycle.
  task automatic apply_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    b0.if_req = v.if_req; b0.dm_rd = v.dm_rd; b0.dm_wr = v.dm_wr;
    b0.if_addr = v.addr; b0.dm_addr = v.addr; b0.dm_wdata = v.wdata;
    b0.mem_rdata = 16'h0BAD;
    sample();
    chk({p, "_c0_mem_en"}, b0.mem_en, 1);
    chk({p, "_c0_mem_addr"}, b0.mem_addr, v.addr);
    chk({p, "_c0_mem_wr"}, b0.mem_wr, v.exp_wr);
    if (v.exp_wr) chk({p, "_c0_mem_wdata"}, b0.mem_wdata, v.wdata);
    chk({p, "_c0_stall"}, v.exp_dm ? b0.dm_stall : b0.if_stall, 1);
    next_cycle();
    sample();
    chk({p, "_c1_mem_en"}, b0.mem_en, 0);
    chk({p, "_c1_busy"}, b0.busy, 1);
    next_cycle();
    b0.mem_rdata = v.mrdata;
    sample();
    chk({p, "_c2_stall"}, v.exp_dm ? b0.dm_stall : b0.if_stall, 1);
    chk({p, "_c2_done"}, b0.if_done | b0.dm_done, 0);
    next_cycle();
    b0.mem_rdata = 16'h0BAD;
    sample();
    chk({p, "_c3_if_done"}, b0.if_done, !v.exp_dm);
    chk({p, "_c3_dm_done"}, b0.dm_done, v.exp_dm);
    chk({p, "_c3_stall"}, b0.if_stall | b0.dm_stall, 0);
    chk({p, "_c3_if_rdata"}, b0.if_rdata, v.exp_if_rdata);
    chk({p, "_c3_dm_rdata"}, b0.dm_rdata, v.exp_dm_rdata);
    chk({p, "_c3_busy"}, b0.busy, 1);
    next_cycle();
    b0.if_req = 0; b0.dm_rd = 0; b0.dm_wr = 0;
    sample();
    chk({p, "_c4_busy"}, b0.busy, 0);
    chk({p, "_c4_done"}, b0.if_done | b0.dm_done, 0);
    chk({p, "_c4_mem_en"}, b0.mem_en, 0);
    next_cycle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h1234, 0, 0, 16'h1234, 16'h0000};
    vecs[1] = '{0, 0, 1, 16'h0100, 16'hBEEF, 16'hDEAD, 1, 1, 16'h1234, 16'h0000};
    vecs[2] = '{0, 1, 0, 16'h0200, 16'h0000, 16'hCAFE, 0, 1, 16'h1234, 16'hCAFE};
    vecs[3] = '{1, 0, 0, 16'hFFFE, 16'h0000, 16'h0F0F, 0, 0, 16'h0F0F, 16'hCAFE};
    vecs[4] = '{0, 0, 1, 16'h0000, 16'h0000, 16'h7E7E, 1, 1, 16'h0F0F, 16'hCAFE};
    vecs[5] = '{0, 1, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 1, 16'h0F0F, 16'hFFFF};

    // reset state
    do_reset();
    sample();
    chk("rst_busy", b0.busy, 0);
    chk("rst_err", b0.err, 0);
    chk("rst_if_rdata", b0.if_rdata, 0);
    chk("rst_dm_rdata", b0.dm_rdata, 0);
    chk("rst_mem_en", b0.mem_en, 0);
    chk("rst_mem_addr", b0.mem_addr, 0);
    chk("rst_mem_wdata", b0.mem_wdata, 0);
    chk("rst_done", b0.if_done | b0.dm_done, 0);
    chk("rst_state", st0, 0);
    chk("rst_u1_busy", b1.busy, 0);
    chk("rst_u1_err", b1.err, 0);
    next_cycle();

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

    // reset in the middle of a fetch; if_rdata holds 0x0F0F going in
    b0.if_req = 1; b0.if_addr = 16'h0010;
    sample();
    chk("rstmid_c0_mem_en", b0.mem_en, 1);
    next_cycle();
    next_cycle();
    b0.mem_rdata = 16'h1234;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    b0.mem_rdata = 16'h0BAD;
    sample();
    chk("rstmid_c3_if_done", b0.if_done, 0);
    chk("rstmid_c3_if_rdata", b0.if_rdata, 0);
    chk("rstmid_c3_dm_rdata", b0.dm_rdata, 0);
    chk("rstmid_c3_busy", b0.busy, 0);
    chk("rstmid_c3_state", st0, 0);
    chk("rstmid_c3_mem_en", b0.mem_en, 1);
    chk("rstmid_c3_mem_addr", b0.mem_addr, 16'h0010);
    chk("rstmid_c3_if_stall", b0.if_stall, 1);
    next_cycle();
    next_cycle();
    b0.mem_rdata = 16'h4321;
    next_cycle();
    b0.mem_rdata = 16'h0BAD;
    sample();
    chk("rstmid_c6_if_done", b0.if_done, 1);
    chk("rstmid_c6_if_rdata", b0.if_rdata, 16'h4321);
    next_cycle();
    b0.if_req = 0;

    // contention: DM issues first, IF waits and issues in cycle 4
    do_reset();
    for (int c = 0; c < 8; c++) begin
      b0.if_req = 1; b0.if_addr = 16'h0A0A;
      b0.dm_rd = (c <= 3); b0.dm_addr = 16'h0B0B;
      b0.mem_rdata = (c == 2) ? 16'h1111 : (c == 6) ? 16'h2222 : 16'h0BAD;
      sample();
      chk($sformatf("cont_c%0d_mem_en", c), b0.mem_en, (c == 0 || c == 4));
      if (c == 0) chk("cont_c0_addr", b0.mem_addr, 16'h0B0B);
      if (c == 4) chk("cont_c4_addr", b0.mem_addr, 16'h0A0A);
      chk($sformatf("cont_c%0d_if_stall", c), b0.if_stall, (c <= 6));
      chk($sformatf("cont_c%0d_dm_done", c), b0.dm_done, (c == 3));
      chk($sformatf("cont_c%0d_if_done", c), b0.if_done, (c == 7));
      next_cycle();
    end
    b0.if_req = 0;
    sample();
    chk("cont_dm_rdata", b0.dm_rdata, 16'h1111);
    chk("cont_if_rdata", b0.if_rdata, 16'h2222);
    next_cycle();

    // both ports requesting continuously for four accesses
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bit exp_dm;
      b0.if_req = 1; b0.if_addr = 16'h1000;
      b0.dm_rd = 1; b0.dm_addr = 16'h2000;
      b0.mem_rdata = 16'h0BAD;
      exp_dm = RR ? (((c / 4) % 2) == 0) : 1'b1;
      sample();
      chk($sformatf("tie_c%0d_mem_en", c), b0.mem_en, (c % 4 == 0));
      if (c % 4 == 0) chk($sformatf("tie_c%0d_addr", c), b0.mem_addr, exp_dm ? 16'h2000 : 16'h1000);
      chk($sformatf("tie_c%0d_dm_done", c), b0.dm_done, (c % 4 == 3) && exp_dm);
      chk($sformatf("tie_c%0d_if_done", c), b0.if_done, (c % 4 == 3) && !exp_dm);
      next_cycle();
    end
    b0.if_req = 0; b0.dm_rd = 0;

    // rd+wr together on both latencies: write issued, err sticky
    do_reset();
    b0.dm_rd = 1; b0.dm_wr = 1; b0.dm_addr = 16'h0300; b0.dm_wdata = 16'h5555;
    b1.dm_rd = 1; b1.dm_wr = 1; b1.dm_addr = 16'h0300; b1.dm_wdata = 16'h5555;
    sample();
    chk("err_c0_u0_mem_wr", b0.mem_wr, 1);
    chk("err_c0_u1_mem_wr", b1.mem_wr, 1);
    chk("err_c0_u0_wdata", b0.mem_wdata, 16'h5555);
    chk("err_c0_u0_err", b0.err, 0);
    next_cycle();
    b0.mem_rdata = 16'h9999; b1.mem_rdata = 16'h9999;
    sample();
    chk("err_c1_u0_err", b0.err, 1);
    chk("err_c1_u1_err", b1.err, 1);
    next_cycle();
    sample();
    chk("err_c2_u1_dm_done", b1.dm_done, 1);
    chk("err_c2_u0_dm_done", b0.dm_done, 0);
    next_cycle();
    b1.dm_rd = 0; b1.dm_wr = 0;
    sample();
    chk("err_c3_u0_dm_done", b0.dm_done, 1);
    chk("err_c3_u1_dm_done", b1.dm_done, 0);
    next_cycle();
    b0.dm_rd = 0; b0.dm_wr = 0;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk($sformatf("err_hold%0d_u0", c), b0.err, 1);
      chk($sformatf("err_hold%0d_u1", c), b1.err, 1);
      chk($sformatf("err_hold%0d_u0_dm_rdata", c), b0.dm_rdata, 0);
      chk($sformatf("err_hold%0d_u1_dm_rdata", c), b1.dm_rdata, 0);
      next_cycle();
    end

    // LATENCY=1 fetch: done two cycles after issue
    b1.if_req = 1; b1.if_addr = 16'h0042;
    sample();
    chk("l1_c0_mem_en", b1.mem_en, 1);
    chk("l1_c0_addr", b1.mem_addr, 16'h0042);
    next_cycle();
    b1.mem_rdata = 16'h7777;
    sample();
    chk("l1_c1_if_stall", b1.if_stall, 1);
    chk("l1_c1_if_done", b1.if_done, 0);
    next_cycle();
    b1.mem_rdata = 16'h0BAD;
    sample();
    chk("l1_c2_if_done", b1.if_done, 1);
    chk("l1_c2_if_rdata", b1.if_rdata, 16'h7777);
    chk("l1_c2_busy", b1.busy, 1);
    next_cycle();
    b1.if_req = 0;
    sample();
    chk("l1_c3_busy", b1.busy, 0);
    next_cycle();

    do_reset();
    sample();
    chk("err_clr_u0", b0.err, 0);
    chk("err_clr_u1", b1.err, 0);
    next_cycle();

    // randomized traffic on the LATENCY=2 instance against a timeline model
    do_reset();
    begin
      int next_free = 0;
      int issue_c = -100;
      int done_c = -100;
      bit cur_dm = 0, cur_wr = 0, last_dm = 0, m_err = 0;
      logic [15:0] cur_addr = '0, m_if = '0, m_dm = '0;
      bit if_p = 0, dm_p = 0, dm_r = 0, dm_w = 0;
      logic [15:0] ia = '0, da = '0, dw = '0;
      for (int c = 0; c < 800; c++) begin
        bit e_if_done, e_dm_done, e_busy, e_en, e_wr, e_err, win_dm;
        logic [15:0] e_addr, e_wd;
        if (!if_p && $urandom_range(0, 2) == 0) begin
          if_p = 1; ia = 16'($urandom);
        end
        if (!dm_p && $urandom_range(0, 2) == 0) begin
          int k;
          k = $urandom_range(0, 15);
          dm_p = 1; dm_r = (k < 7) || (k == 15); dm_w = (k >= 7);
          da = 16'($urandom); dw = 16'($urandom);
        end
        b0.if_req = if_p; b0.if_addr = ia;
        b0.dm_rd = dm_p & dm_r; b0.dm_wr = dm_p & dm_w;
        b0.dm_addr = da; b0.dm_wdata = dw;

        e_if_done = (c == done_c) && !cur_dm;
        e_dm_done = (c == done_c) && cur_dm;
        e_busy = (c > issue_c) && (c <= done_c);
        e_err = m_err;
        if (c == done_c && !cur_wr) begin
          if (cur_dm) m_dm = memfn(cur_addr);
          else m_if = memfn(cur_addr);
        end
        e_en = 0; e_wr = 0; e_addr = '0; e_wd = '0;
        if (c >= next_free && (if_p || dm_p)) begin
          win_dm = dm_p && (!if_p || (RR ? !last_dm : 1'b1));
          last_dm = win_dm; cur_dm = win_dm;
          cur_wr = win_dm && dm_w;
          cur_addr = win_dm ? da : ia;
          if (win_dm && dm_r && dm_w) m_err = 1;
          issue_c = c; done_c = c + 3; next_free = c + 4;
          e_en = 1; e_wr = cur_wr; e_addr = cur_addr; e_wd = dw;
        end
        b0.mem_rdata = (c == issue_c + 2) ? memfn(cur_addr) : 16'($urandom);

        sample();
        chk("rnd_mem_en", b0.mem_en, e_en);
        if (e_en) begin
          chk("rnd_mem_addr", b0.mem_addr, e_addr);
          chk("rnd_mem_wr", b0.mem_wr, e_wr);
          if (e_wr) chk("rnd_mem_wdata", b0.mem_wdata, e_wd);
        end
        chk("rnd_if_done", b0.if_done, e_if_done);
        chk("rnd_dm_done", b0.dm_done, e_dm_done);
        chk("rnd_if_stall", b0.if_stall, if_p && !e_if_done);
        chk("rnd_dm_stall", b0.dm_stall, dm_p && !e_dm_done);
        chk("rnd_if_rdata", b0.if_rdata, m_if);
        chk("rnd_dm_rdata", b0.dm_rdata, m_dm);
        chk("rnd_busy", b0.busy, e_busy);
        chk("rnd_err", b0.err, e_err);
        if (e_if_done) if_p = 0;
        if (e_dm_done) dm_p = 0;
        next_cycle();
      end
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
